// File: rtl/load_align_sequencer_pkg.sv
// Shared types for the load sequencer: access types, FSM states and access-size lookup.
// XLEN_DEF is 32, or 64 when XLEN_64 is defined.
package load_align_sequencer_pkg;

`ifdef XLEN_64
  localparam int XLEN_DEF = 64;
`else
  localparam int XLEN_DEF = 32;
`endif

  typedef enum logic [2:0] {
    BYTE,
    HALF_WORD,
    WORD,
    NO_TRUNC,
    BYTE_UNSIGNED,
    HALF_WORD_UNSIGNED,
    WORD_UNSIGNED
  } truncType;

  typedef enum logic [2:0] {
    IDLE,
    REQ1,
    WAIT1,
    REQ2,
    WAIT2,
    RESP,
    DRAIN
  } loadSeqState;

  function automatic int unsigned truncSize(truncType t);
    case (t)
      BYTE, BYTE_UNSIGNED:           return 1;
      HALF_WORD, HALF_WORD_UNSIGNED: return 2;
      WORD, WORD_UNSIGNED:           return 4;
      default:                       return XLEN_DEF / 8;
    endcase
  endfunction

endpackage

// File: rtl/load_align_sequencer_merge.sv
// load_merge: joins the two captured words and right-justifies the addressed bytes.
// Purely combinational; B is zero when only one word was read.
module load_merge #(
  parameter int XLEN = 32,
  parameter int OFFW = 2
) (
  input  logic [XLEN-1:0] WordA,
  input  logic [XLEN-1:0] WordB,
  input  logic [OFFW-1:0] Offset,
  output logic [XLEN-1:0] TruncData
);

  assign TruncData = XLEN'({WordB, WordA} >> {Offset, 3'b000});

endmodule

// File: rtl/load_align_sequencer.sv
// Sequences one or two aligned data-memory reads per load and hands right-justified data to the truncator.
// Optional MISALIGNED_SPLIT_EN: split misaligned loads; otherwise they raise LoadMisaligned with no memory access.
module load_align_sequencer
  import load_align_sequencer_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  localparam int OFFW = $clog2(XLEN/8)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            LoadReq,
  input  logic [XLEN-1:0] LoadAddr,
  input  truncType        LoadTruncType,
  input  logic            Flush,
  output logic            LoadReady,
  output logic            Stall,
  output logic            MemReq,
  output logic [XLEN-1:0] MemAddr,
  input  logic            MemGnt,
  input  logic            MemRdValid,
  input  logic [XLEN-1:0] MemRdData,
  output logic            DataValid,
  output logic [XLEN-1:0] TruncData,
  output truncType        TruncTypeOut,
  output logic [OFFW-1:0] TruncSrc,
  output logic            LoadMisaligned
);

  localparam int NBYTES = XLEN / 8;
  typedef logic [OFFW+1:0] ext_t;

  loadSeqState     state_q, state_d;
  logic [XLEN-1:0] base_q, base_d;
  logic [OFFW-1:0] off_q, off_d;
  truncType        type_q, type_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] word_a_q, word_a_d;
  logic [XLEN-1:0] word_b;
  logic [OFFW-1:0] req_off;

  assign req_off = LoadAddr[OFFW-1:0];

`ifdef MISALIGNED_SPLIT_EN
  logic            cross_q, cross_d;
  logic [XLEN-1:0] word_b_q, word_b_d;
  logic            req_cross;

  assign req_cross = (ext_t'(req_off) + ext_t'(truncSize(LoadTruncType))) > ext_t'(NBYTES);
  assign word_b    = word_b_q;
`else
  logic            req_mis;

  // Full-width accesses are flagged on any offset: they can never be served by one read.
  always_comb begin
    req_mis = 1'b0;
    case (LoadTruncType)
      HALF_WORD, HALF_WORD_UNSIGNED: req_mis = req_off[0];
      WORD, WORD_UNSIGNED:           req_mis = |req_off[1:0];
      NO_TRUNC:                      req_mis = |req_off;
      default:                       req_mis = 1'b0;
    endcase
  end

  assign word_b = '0;
`endif

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    off_d    = off_q;
    type_d   = type_q;
    mis_d    = mis_q;
    word_a_d = word_a_q;
`ifdef MISALIGNED_SPLIT_EN
    cross_d  = cross_q;
    word_b_d = word_b_q;
`endif
    MemReq   = 1'b0;
    MemAddr  = '0;
    case (state_q)
      IDLE: begin
        if (LoadReq) begin
          base_d = {LoadAddr[XLEN-1:OFFW], {OFFW{1'b0}}};
          off_d  = req_off;
          type_d = LoadTruncType;
`ifdef MISALIGNED_SPLIT_EN
          cross_d  = req_cross;
          word_b_d = '0;
          mis_d    = 1'b0;
          state_d  = REQ1;
`else
          mis_d   = req_mis;
          state_d = req_mis ? RESP : REQ1;
`endif
        end
      end
      REQ1: begin
        MemReq  = 1'b1;
        MemAddr = base_q;
        if (MemGnt)     state_d = Flush ? DRAIN : WAIT1;
        else if (Flush) state_d = IDLE;
      end
      WAIT1: begin
        // Data arriving with the flush is the read being abandoned: nothing left to drain.
        if (Flush) begin
          state_d = MemRdValid ? IDLE : DRAIN;
        end else if (MemRdValid) begin
          word_a_d = MemRdData;
`ifdef MISALIGNED_SPLIT_EN
          state_d  = cross_q ? REQ2 : RESP;
`else
          state_d  = RESP;
`endif
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      REQ2: begin
        MemReq  = 1'b1;
        MemAddr = base_q + XLEN'(NBYTES);
        if (MemGnt)     state_d = Flush ? DRAIN : WAIT2;
        else if (Flush) state_d = IDLE;
      end
      WAIT2: begin
        if (Flush) begin
          state_d = MemRdValid ? IDLE : DRAIN;
        end else if (MemRdValid) begin
          word_b_d = MemRdData;
          state_d  = RESP;
        end
      end
`endif
      RESP:    state_d = IDLE;
      DRAIN:   if (MemRdValid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      off_q    <= '0;
      type_q   <= BYTE;
      mis_q    <= 1'b0;
      word_a_q <= '0;
`ifdef MISALIGNED_SPLIT_EN
      cross_q  <= 1'b0;
      word_b_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      off_q    <= off_d;
      type_q   <= type_d;
      mis_q    <= mis_d;
      word_a_q <= word_a_d;
`ifdef MISALIGNED_SPLIT_EN
      cross_q  <= cross_d;
      word_b_q <= word_b_d;
`endif
    end
  end

  assign LoadReady      = (state_q == IDLE);
  assign Stall          = (state_q != IDLE);
  assign DataValid      = (state_q == RESP) && !mis_q && !Flush;
  assign LoadMisaligned = (state_q == RESP) && mis_q && !Flush;
  assign TruncTypeOut   = type_q;
  assign TruncSrc       = '0;

  load_merge #(
    .XLEN (XLEN),
    .OFFW (OFFW)
  ) u_merge (
    .WordA     (word_a_q),
    .WordB     (word_b),
    .Offset    (off_q),
    .TruncData (TruncData)
  );

endmodule

// File: tb/tb_load_align_sequencer.sv
// Self-checking bench for load_align_sequencer (XLEN 32): vector table, hand-written flush/reset
// sequences and randomized loads against a byte-level memory model.
module tb_load_align_sequencer;
  import load_align_sequencer_pkg::*;

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk, reset, LoadReq, Flush;
  logic [31:0] LoadAddr, MemAddr, MemRdData, TruncData;
  truncType    LoadTruncType, TruncTypeOut;
  logic        LoadReady, Stall, MemReq, MemGnt, MemRdValid, DataValid, LoadMisaligned;
  logic [1:0]  TruncSrc;

  int checks = 0;
  int errors = 0;

  // memory side: automatic responder or manual drive
  bit          auto_mem = 1'b1;
  logic        rsp_gnt = 1'b0, rsp_vld = 1'b0, man_gnt = 1'b0, man_vld = 1'b0;
  logic [31:0] rsp_data = '0, man_data = '0;
  int          gnt_wait_max = 0, rd_wait_max = 0;
  logic [31:0] mem_q [logic [31:0]];
  logic [31:0] rd_addrs [$];

  assign MemGnt     = auto_mem ? rsp_gnt  : man_gnt;
  assign MemRdValid = auto_mem ? rsp_vld  : man_vld;
  assign MemRdData  = auto_mem ? rsp_data : man_data;

  load_align_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .LoadReq        (LoadReq),
    .LoadAddr       (LoadAddr),
    .LoadTruncType  (LoadTruncType),
    .Flush          (Flush),
    .LoadReady      (LoadReady),
    .Stall          (Stall),
    .MemReq         (MemReq),
    .MemAddr        (MemAddr),
    .MemGnt         (MemGnt),
    .MemRdValid     (MemRdValid),
    .MemRdData      (MemRdData),
    .DataValid      (DataValid),
    .TruncData      (TruncData),
    .TruncTypeOut   (TruncTypeOut),
    .TruncSrc       (TruncSrc),
    .LoadMisaligned (LoadMisaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_q.exists(a)) return mem_q[a];
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F96;
  endfunction

  initial begin : responder
    bit          pending = 1'b0;
    int          rd_delay = 0, gnt_delay = 0;
    logic [31:0] data_l = '0;
    forever begin
      @(negedge clk);
      if (auto_mem) begin
        rsp_gnt = 1'b0;
        rsp_vld = 1'b0;
        if (pending) begin
          if (rd_delay == 0) begin
            rsp_vld  = 1'b1;
            rsp_data = data_l;
            pending  = 1'b0;
          end else rd_delay--;
        end else if (MemReq) begin
          if (gnt_delay == 0) begin
            rsp_gnt = 1'b1;
            rd_addrs.push_back(MemAddr);
            data_l    = mem_rd(MemAddr);
            pending   = 1'b1;
            rd_delay  = $urandom_range(0, rd_wait_max);
            gnt_delay = $urandom_range(0, gnt_wait_max);
          end else gnt_delay--;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Expected behaviour from the architectural rules, one byte at a time.
  function automatic void model(input logic [31:0] addr, input truncType t, output bit mis,
                                output logic [31:0] data, output int n, output logic [31:0] a0,
                                output logic [31:0] a1);
    int unsigned size, off;
    bit          natural_mis;
    size = (t == BYTE || t == BYTE_UNSIGNED) ? 1 :
           (t == HALF_WORD || t == HALF_WORD_UNSIGNED) ? 2 : 4;
    off = addr % 4;
    natural_mis = (addr % size) != 0;
    mis = natural_mis && !SPLIT;
    n   = mis ? 0 : ((off + size > 4) ? 2 : 1);
    a0  = addr & ~32'h3;
    a1  = a0 + 32'd4;
    data = '0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] b, w;
      b = addr + i;
      w = b & ~32'h3;
      if (w == a0 || (n == 2 && w == a1)) data[8*i +: 8] = 8'(mem_rd(w) >> (8 * (b % 4)));
    end
  endfunction

  task automatic run_load(input string tag, input logic [31:0] addr, input truncType t,
                          input bit exp_mis, input logic [31:0] exp_data, input int exp_n,
                          input logic [31:0] exp_a0, input logic [31:0] exp_a1, input int exp_lat);
    int cyc;
    bit seen;
    @(negedge clk);
    chk({tag, "_ready"}, LoadReady, 1);
    rd_addrs.delete();
    LoadReq = 1'b1; LoadAddr = addr; LoadTruncType = t;
    @(negedge clk);
    LoadReq = 1'b0;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 100) begin
      if (DataValid || LoadMisaligned) seen = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    chk({tag, "_done"}, seen, 1);
    chk({tag, "_misaligned"}, LoadMisaligned, exp_mis);
    chk({tag, "_datavalid"}, DataValid, !exp_mis);
    chk({tag, "_stall"}, Stall, 1);
    chk({tag, "_type"}, TruncTypeOut, t);
    if (!exp_mis) chk({tag, "_data"}, TruncData, exp_data);
    chk({tag, "_nreads"}, rd_addrs.size(), exp_n);
    if (exp_n > 0) chk({tag, "_addr0"}, (rd_addrs.size() > 0) ? rd_addrs[0] : 32'hxxxxxxxx, exp_a0);
    if (exp_n > 1) chk({tag, "_addr1"}, (rd_addrs.size() > 1) ? rd_addrs[1] : 32'hxxxxxxxx, exp_a1);
    if (exp_lat >= 0) chk({tag, "_latency"}, cyc, exp_lat);
    @(negedge clk);
    chk({tag, "_pulse_end"}, DataValid | LoadMisaligned, 0);
    chk({tag, "_ready_after"}, LoadReady, 1);
  endtask

  typedef struct {
    logic [31:0] addr;
    truncType    t;
    logic [31:0] w0, w1;
    bit          mis;
    logic [31:0] data;
    int          n;
    int          lat;
  } vec_t;
  vec_t vecs [$];

  task automatic add_vec(input logic [31:0] addr, input truncType t, input logic [31:0] w0,
                         input logic [31:0] w1, input bit mis, input logic [31:0] data,
                         input int n, input int lat);
    vec_t v;
    v.addr = addr; v.t = t; v.w0 = w0; v.w1 = w1;
    v.mis = mis; v.data = data; v.n = n; v.lat = lat;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] base, c_addr, e_data, e_a0, e_a1, r_addr;
    bit          e_mis;
    int          e_n, n_acc;
    truncType    rt;

    reset = 1'b1; LoadReq = 1'b0; LoadAddr = '0; LoadTruncType = WORD; Flush = 1'b0;

    // ---- reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", LoadReady, 1);
    chk("rst_stall", Stall, 0);
    chk("rst_memreq", MemReq, 0);
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_datavalid", DataValid, 0);
    chk("rst_misaligned", LoadMisaligned, 0);
    chk("rst_truncdata", TruncData, 0);
    chk("rst_trunctype", TruncTypeOut, 0);
    chk("rst_truncsrc", TruncSrc, 0);

    // ---- directed vectors, zero-wait memory
    add_vec(32'h100, WORD, 32'hDEADBEEF, 32'h0, 0, 32'hDEADBEEF, 1, 3);
    add_vec(32'h102, BYTE, 32'h11223344, 32'h0, 0, 32'h00001122, 1, 3);
    add_vec(32'h103, HALF_WORD, 32'h11223344, 32'h55667788, !SPLIT, 32'h66778811, SPLIT ? 2 : 0, SPLIT ? 5 : 1);
    add_vec(32'h102, HALF_WORD_UNSIGNED, 32'hA1B2C3D4, 32'h0, 0, 32'h0000A1B2, 1, 3);
    add_vec(32'h103, BYTE_UNSIGNED, 32'hA1B2C3D4, 32'h0, 0, 32'h000000A1, 1, 3);
    add_vec(32'h101, WORD, 32'h11223344, 32'h55667788, !SPLIT, 32'h88112233, SPLIT ? 2 : 0, SPLIT ? 5 : 1);
    add_vec(32'h105, HALF_WORD, 32'h11223344, 32'h0, !SPLIT, 32'h00112233, SPLIT ? 1 : 0, SPLIT ? 3 : 1);
    add_vec(32'hFFFFFFFE, WORD, 32'hCAFEBABE, 32'h01020304, !SPLIT, 32'h0304CAFE, SPLIT ? 2 : 0, SPLIT ? 5 : 1);
    add_vec(32'h200, NO_TRUNC, 32'h0BADF00D, 32'h0, 0, 32'h0BADF00D, 1, 3);
    add_vec(32'h1FF, BYTE, 32'h7E000000, 32'h0, 0, 32'h0000007E, 1, 3);
    add_vec(32'h106, HALF_WORD, 32'hBEEF1234, 32'h0, 0, 32'h0000BEEF, 1, 3);
    foreach (vecs[i]) begin
      base = vecs[i].addr & ~32'h3;
      mem_q[base] = vecs[i].w0;
      mem_q[base + 32'd4] = vecs[i].w1;
      run_load($sformatf("vec%0d", i), vecs[i].addr, vecs[i].t, vecs[i].mis, vecs[i].data,
               vecs[i].n, base, base + 32'd4, vecs[i].lat);
    end

    // ---- flush in WAIT1: stale data drained, next load waits for the drain
    auto_mem = 1'b0;
    @(negedge clk); LoadReq = 1'b1; LoadAddr = 32'h100; LoadTruncType = WORD;
    @(negedge clk); LoadReq = 1'b0; #1;
    chk("fl_w1_memreq", MemReq, 1);
    man_gnt = 1'b1;
    @(negedge clk); man_gnt = 1'b0; Flush = 1'b1; #1;
    chk("fl_w1_stall", Stall, 1);
    @(negedge clk); Flush = 1'b0; LoadReq = 1'b1; LoadAddr = 32'h300; #1;
    chk("fl_drain_not_ready", LoadReady, 0);
    chk("fl_drain_no_memreq", MemReq, 0);
    @(negedge clk); man_vld = 1'b1; man_data = 32'hCAFEF00D; #1;
    chk("fl_drain_not_ready2", LoadReady, 0);
    chk("fl_drain_no_dv", DataValid, 0);
    @(negedge clk); man_vld = 1'b0; #1;
    chk("fl_after_drain_ready", LoadReady, 1);
    chk("fl_after_drain_no_dv", DataValid, 0);
    @(negedge clk); LoadReq = 1'b0; #1;
    chk("fl_next_memreq", MemReq, 1);
    chk("fl_next_memaddr", MemAddr, 32'h300);
    man_gnt = 1'b1;
    @(negedge clk); man_gnt = 1'b0; man_vld = 1'b1; man_data = 32'h12345678;
    @(negedge clk); man_vld = 1'b0; #1;
    chk("fl_next_dv", DataValid, 1);
    chk("fl_next_data", TruncData, 32'h12345678);
    @(negedge clk); #1;
    chk("fl_next_ready", LoadReady, 1);

    // ---- flush in REQ1 without grant: back to IDLE, no read
    LoadReq = 1'b1; LoadAddr = 32'h400; LoadTruncType = WORD;
    @(negedge clk); LoadReq = 1'b0; Flush = 1'b1; #1;
    chk("fl_req_memreq", MemReq, 1);
    @(negedge clk); Flush = 1'b0; #1;
    chk("fl_req_ready", LoadReady, 1);
    chk("fl_req_no_memreq", MemReq, 0);

    // ---- flush in RESP suppresses the pulse
    LoadReq = 1'b1; LoadAddr = 32'h500;
    @(negedge clk); LoadReq = 1'b0; man_gnt = 1'b1;
    @(negedge clk); man_gnt = 1'b0; man_vld = 1'b1; man_data = 32'h55AA55AA;
    @(negedge clk); man_vld = 1'b0; Flush = 1'b1; #1;
    chk("fl_resp_no_dv", DataValid, 0);
    chk("fl_resp_no_mis", LoadMisaligned, 0);
    @(negedge clk); Flush = 1'b0; #1;
    chk("fl_resp_ready", LoadReady, 1);
    chk("fl_resp_no_dv2", DataValid, 0);

    // ---- reset while waiting on the last read; the late data is ignored
    c_addr = SPLIT ? 32'h101 : 32'h100;
    n_acc  = SPLIT ? 2 : 1;
    LoadReq = 1'b1; LoadAddr = c_addr; LoadTruncType = WORD_UNSIGNED;
    @(negedge clk); LoadReq = 1'b0;
    for (int g = 0; g < n_acc; g++) begin
      #1;
      chk($sformatf("rs_req%0d", g), MemReq, 1);
      man_gnt = 1'b1;
      @(negedge clk); man_gnt = 1'b0;
      if (g < n_acc - 1) begin
        man_vld = 1'b1; man_data = 32'h0F0F0F0F;
        @(negedge clk); man_vld = 1'b0;
      end
    end
    reset = 1'b1;
    @(negedge clk); #1;
    chk("rs_ready", LoadReady, 1);
    chk("rs_stall", Stall, 0);
    chk("rs_memreq", MemReq, 0);
    chk("rs_memaddr", MemAddr, 0);
    chk("rs_dv", DataValid, 0);
    chk("rs_mis", LoadMisaligned, 0);
    chk("rs_data", TruncData, 0);
    chk("rs_type", TruncTypeOut, 0);
    reset = 1'b0; man_vld = 1'b1; man_data = 32'hBAD0BAD0;
    @(negedge clk); man_vld = 1'b0; #1;
    chk("rs_late_dv", DataValid, 0);
    chk("rs_late_ready", LoadReady, 1);
    chk("rs_late_data", TruncData, 0);
    chk("rs_late_stall", Stall, 0);

    // ---- randomized loads with random grant/data delays
    auto_mem = 1'b1;
    gnt_wait_max = 2;
    rd_wait_max  = 3;
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 6))
        0:       rt = BYTE;
        1:       rt = BYTE_UNSIGNED;
        2:       rt = HALF_WORD;
        3:       rt = HALF_WORD_UNSIGNED;
        4:       rt = WORD;
        5:       rt = WORD_UNSIGNED;
        default: rt = NO_TRUNC;
      endcase
      if ($urandom_range(0, 9) == 0) r_addr = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      else r_addr = 32'($urandom_range(0, 4095));
      if (rt == NO_TRUNC) r_addr[1:0] = 2'b00;
      model(r_addr, rt, e_mis, e_data, e_n, e_a0, e_a1);
      run_load($sformatf("rnd%0d", k), r_addr, rt, e_mis, e_data, e_n, e_a0, e_a1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_align_sequencer.md
# load_align_sequencer

Multi-cycle controller that issues data-memory reads for loads and feeds the writeback truncator. It computes aligned word addresses and sequences one or two memory reads per load. It merges and right-justifies the returned data so the truncator always sees the loaded value at byte offset 0. It owns the memory read handshake, the pipeline stall, flush handling and misaligned-load reporting.

## Interface
Parameters
- `XLEN`, from `parameters.svh`, default 32: data and address width; 64 when `XLEN_64` is defined.
- `OFFW`, default `$clog2(XLEN/8)`: byte-offset width. Derived; not overridden.

Ports
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `LoadReq`  in  1  load request from the memory stage.
- `LoadAddr`  in  XLEN  byte address.
- `LoadTruncType`  in  truncType  access type.
- `Flush`  in  1  abandons the in-flight load.
- `LoadReady`  out  1  high only in IDLE; a load is accepted when `LoadReq && LoadReady`.
- `Stall`  out  1  high from the cycle after accept through the DataValid cycle, inclusive.
- `MemReq`  out  1  read request; held until granted.
- `MemAddr`  out  XLEN  read address; always aligned to XLEN/8.
- `MemGnt`  in  1  request accepted this cycle.
- `MemRdValid`  in  1  read data valid.
- `MemRdData`  in  XLEN  read data.
- `DataValid`  out  1  one-cycle pulse with the result.
- `TruncData`  out  XLEN  merged, right-justified load data for the truncator.
- `TruncTypeOut`  out  truncType  latched type for the truncator.
- `TruncSrc`  out  OFFW  constant `'0`.
- `LoadMisaligned`  out  1  one-cycle exception pulse.

## Operation
- Size: BYTE/BYTE_UNSIGNED = 1; HALF_WORD/HALF_WORD_UNSIGNED = 2; WORD/WORD_UNSIGNED = 4; NO_TRUNC = XLEN/8.
- Offset is `LoadAddr[OFFW-1:0]`. Aligned base is the address with those bits cleared.
- Natural misalignment: half when offset[0] is set; word when offset[1:0] is non-zero; NO_TRUNC on XLEN 64 when offset[2:0] is non-zero.
- A load crosses when `offset + size > XLEN/8`, evaluated in OFFW+2-bit arithmetic.
- Latched on accept: base, offset, type, crosses flag.
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP, DRAIN.
  - IDLE → REQ1 on accept. Misaligned loads with `MISALIGNED_SPLIT_EN` off instead go IDLE → RESP, with no memory access.
  - REQ1 drives `MemReq`, `MemAddr`=base. On `MemGnt` → WAIT1.
  - WAIT1: on `MemRdValid`, capture word A. If crosses → REQ2, else → RESP.
  - REQ2 drives `MemAddr`=base+XLEN/8, wrapping modulo 2^XLEN. On `MemGnt` → WAIT2.
  - WAIT2: on `MemRdValid`, capture word B → RESP.
  - RESP pulses `DataValid` (or `LoadMisaligned`) → IDLE.
  - Flush in REQ1/REQ2 without `MemGnt` → IDLE.
  - Flush in WAIT1/WAIT2, or in REQ with `MemGnt` the same cycle → DRAIN.
  - DRAIN discards the next `MemRdValid` → IDLE.
  - Flush in RESP suppresses both pulses → IDLE.
- Merge: `TruncData` = low XLEN bits of `{B,A} >> (offset*8)`. B is `'0` for a single access.
- `MemRdValid` is ignored in IDLE, REQ1, REQ2 and RESP.
- Reset in any state → IDLE. All outputs 0, `LoadReady`=1, captured words cleared.

## Timing
- At most one outstanding read.
- Memory grant is combinational and same-cycle. Read data arrives at least one cycle after grant.
- Aligned load, zero-wait memory: accept at cycle 0, `MemReq`/`MemGnt` at cycle 1, `MemRdValid` at cycle 2, `DataValid` at cycle 3. A split load adds 2 cycles.
- `DataValid`, `TruncData` and `TruncTypeOut` are registered and valid together in RESP.
- `LoadMisaligned` is registered, 1 cycle after accept.
- `Stall` is combinational from state: high in every state except IDLE.

## Configuration
- `MISALIGNED_SPLIT_EN` defined:
  - A misaligned non-crossing load performs one read and is shifted.
  - A crossing load performs two reads.
  - `LoadMisaligned` is never asserted.
- `MISALIGNED_SPLIT_EN` undefined:
  - REQ2, WAIT2 and word B are not generated.
  - A naturally misaligned load asserts `LoadMisaligned` with no memory access.
  - Aligned loads behave identically to the defined case.

## Structure
- Add to the `HighLevelControl` package:
  - the `loadSeqState` enum;
  - the function `truncSize(truncType)`.
- One combinational sub-module, `load_merge`, holds the {B,A} shift and merge. Inputs: A, B, offset. Output: `TruncData`.
- Output feeds the existing truncator directly, with `TruncSrc` tied to 0.

## Test plan
- XLEN 32; LW at 0x100; memory 0xDEADBEEF → single `MemAddr` 0x100; `TruncData` 0xDEADBEEF; `DataValid` at cycle 3.
- LB at 0x102; word 0x11223344 → one read at 0x100; `TruncData` 0x00001122.
- Macro on; LH at 0x103; 0x100=0x11223344, 0x104=0x55667788 → reads at 0x100 then 0x104; `TruncData` 0x66778811; `DataValid` at cycle 5.
- Macro off; LH at 0x103 → no `MemReq`; `LoadMisaligned` pulse at cycle 1; `LoadReady` high at cycle 2.
- Flush in WAIT1, then `MemRdValid` with 0xCAFEF00D → no `DataValid`. The next LW is accepted only after DRAIN consumes the stale data.
- Reset asserted in WAIT2 → next cycle IDLE; all outputs 0; a late `MemRdValid` is ignored.
